// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a little-endian byte stream into 32-bit words,
// writes them from address 0, zero-fills the remainder and holds the core until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic [31:0]           checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic [1:0]            byte_cnt_reg;
  logic                  last_reg;
  logic [7:0]            lane_reg [3];

  logic                  xfer;
  logic                  count_ok;
  logic                  last_word;
  logic [31:0]           word_next;

  assign in_ready  = (state_reg == LOAD) && !last_reg;
  assign busy      = (state_reg == LOAD) || (state_reg == FILL);
  assign done      = (state_reg == DONE);
  assign cpu_hold  = (state_reg != DONE);

  assign xfer      = in_valid && in_ready;
  assign count_ok  = (word_count != '0) && (word_count <= DEPTH_W);
  assign last_word = ({1'b0, idx_reg} == (count_reg - 1'b1));
  assign word_next = {in_byte, lane_reg[2], lane_reg[1], lane_reg[0]};

  // Lower three bytes of the word under assembly; the fourth goes straight to wdata.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          lane_reg[gi] <= '0;
        else if (xfer && (byte_cnt_reg == 2'(gi)))
          lane_reg[gi] <= in_byte;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      idx_reg      <= '0;
      byte_cnt_reg <= '0;
      last_reg     <= 1'b0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      checksum     <= '0;
      error        <= 1'b0;
    end else begin
      we    <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (!count_ok) begin
              error <= 1'b1;
            end else begin
              count_reg    <= word_count;
              idx_reg      <= '0;
              byte_cnt_reg <= '0;
              checksum     <= '0;
              last_reg     <= 1'b0;
              state_reg    <= LOAD;
            end
          end
        end
        LOAD: begin
          // last_reg marks the cycle the final data word is on the write port.
          if (last_reg) begin
            last_reg <= 1'b0;
            if (count_reg < DEPTH_W) begin
              state_reg <= FILL;
              we        <= 1'b1;
              waddr     <= count_reg[ADDR_WIDTH-1:0];
              wdata     <= '0;
            end else begin
              state_reg <= DONE;
            end
          end else if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == 2'd3) begin
              we       <= 1'b1;
              waddr    <= idx_reg;
              wdata    <= word_next;
              checksum <= checksum ^ word_next;
              if (last_word)
                last_reg <= 1'b1;
              else
                idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        FILL: begin
          if (waddr == LAST_ADDR) begin
            state_reg <= DONE;
          end else begin
            we    <= 1'b1;
            waddr <= waddr + 1'b1;
            wdata <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions, and writes them sequentially into a writable instruction memory starting at address 0.
- After the last program word, zero-fills every remaining location so that unused addresses read 32'h00000000.
- Holds the processor core off (cpu_hold) from reset until a load completes.
- Sits between the host/debug link and the imem write port.

Parameters:
- ADDR_WIDTH, 6, imem address width.
- DEPTH, 64, number of imem words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load, sampled only in IDLE or DONE
- word_count  input  ADDR_WIDTH+1  number of program words, sampled with start
- in_valid  input  1  byte on in_byte is valid
- in_byte  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- we  output  1  imem write enable
- waddr  output  ADDR_WIDTH  imem write address
- wdata  output  32  imem write data
- checksum  output  32  running XOR of all words written in the current load, fill zeros included
- busy  output  1  high in LOAD or FILL
- done  output  1  high in DONE
- error  output  1  one-cycle pulse on an illegal word_count
- cpu_hold  output  1  high whenever the state is not DONE

Behaviour:
- Reset (async, reset=0):
  - State is IDLE.
  - in_ready, we, busy, done and error are 0.
  - waddr, wdata, checksum and the byte counter are 0.
  - cpu_hold is 1.
- States: IDLE, LOAD, FILL, DONE.
- IDLE/DONE, start=1:
  - word_count==0 or word_count>DEPTH: error=1 for one cycle; state unchanged; no writes.
  - Otherwise: latch word_count; clear word index, byte counter and checksum; go to LOAD next cycle.
  - done drops and cpu_hold rises in the cycle after start.
- start is ignored in LOAD and FILL.
- LOAD:
  - in_ready=1 in every LOAD cycle, including the cycle in which we is high.
  - A byte transfers when in_valid && in_ready.
  - Byte k (k=0..3) of a word lands in bits [8k+7:8k].
  - On the 4th transferred byte, the next cycle gives: we=1 for one cycle, waddr=word index, wdata=assembled word, checksum ^= word. The word index then increments.
  - Throughput: one word per 4 handshake cycles; no bubbles are required between words.
  - in_valid low simply stalls; partial bytes are held indefinitely.
- LOAD -> FILL/DONE:
  - When the write of word word_count-1 issues, the next state is FILL if word_count<DEPTH, else DONE.
  - in_ready is 0 from that cycle on.
- FILL:
  - in_ready=0.
  - One write per cycle: we=1, wdata=0, waddr = word_count .. DEPTH-1 in ascending order.
  - After the write to DEPTH-1: DONE.
  - FILL lasts exactly DEPTH-word_count cycles.
- DONE:
  - done=1, cpu_hold=0, busy=0, we=0, in_ready=0.
  - waddr, wdata and checksum hold their last values.
- Word index and waddr never wrap: the maximum is DEPTH-1, and a load ends there.
- Reset asserted mid-LOAD or mid-FILL:
  - Immediate return to IDLE with the reset values above; we drops asynchronously.
  - Partially written imem contents are not restored.
- Bytes presented while in_ready=0 are not consumed and not counted.

Test Plan:
- Load of 2 words:
  - Stimulus: after reset, start with word_count=2; bytes 00 00 00 f8 01 80 00 f8 with in_valid held high.
  - Writes: f8000000@0, then f8008001@1, then 62 FILL writes of 0 at addresses 2..63.
  - End state: done=1, cpu_hold=0, checksum=00008001.
- Full 64-word load with gapped in_valid (1 cycle on, 2 off):
  - Exactly 64 we pulses at addresses 0..63; no FILL cycles.
  - Data equals the packed bytes; in_ready never drops before the last byte.
- Illegal counts:
  - start with word_count=0 -> error pulse, state stays IDLE, cpu_hold=1, no we.
  - start with word_count=65 -> same response.
- Reset mid-load:
  - Stimulus: word_count=4; drop reset after 6 bytes (word 0 written, word 1 partial).
  - Required: state IDLE, we=0, cpu_hold=1.
  - A new start with word_count=1 and bytes 0e 01 0e cb writes cb0e010e@0.
- Reload from DONE:
  - Stimulus: after a completed load, start with word_count=19, streaming instructions f8000000..f803800f.
  - Required: cpu_hold returns to 1 the cycle after start; 19 data writes followed by 45 zero writes; cpu_hold returns to 0 on entry to DONE.
  - Bytes offered during FILL are not consumed.
